mux_select_pipe: RTL and testbench

- Parametrised registered N-way, W-bit operand selector for the ALU datapath.
- Generalises the fixed 8-way 8-bit mux to configurable width and input count.
- Adds a valid/ready handshake with a 2-entry skid buffer so it can sit between pipeline stages.
- Adds an auto-scan mode that steps the select through all inputs in round-robin order.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_select_comb.sv | 24 ++
 rtl/mux_select_pipe.sv | 108 ++++++++++
 tb/tb_mux_select_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered operand selector: clog2, input-count limit and the
// captured-word layout. MUX_WORD_T builds the packed {data, sel, err} word for given widths.
`ifndef MUX_WORD_T
`define MUX_WORD_T(W, S) struct packed { logic [(W)-1:0] data; logic [(S)-1:0] sel; logic err; }
`endif

package mux_pkg;

  localparam int unsigned MUX_MAX_IN = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_select_comb.sv
// Purely combinational NUM_IN-way, WIDTH-bit selector; indices >= NUM_IN give zero data and
// raise o_err.
module mux_select_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [SEL_W-1:0]        i_idx,
  input  logic [NUM_IN*WIDTH-1:0] i_d,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_err
);

  always_comb begin
    o_data = '0;
    o_err  = (32'(i_idx) >= NUM_IN);
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (i_idx == SEL_W'(i)) o_data = i_d[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_select_pipe.sv
// Registered N-way operand selector with valid/ready handshake, skid entry and round-robin scan.
// Define MUX_SELECT_PARITY_EN to add the q_par even-parity output.
module mux_select_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    scan,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        q,
  output logic [SEL_W-1:0]        q_sel,
  output logic                    q_err,
`ifdef MUX_SELECT_PARITY_EN
  output logic                    q_par,
`endif
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (SEL_W != clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_select_pipe: SEL_W must equal clog2(NUM_IN)");
  end
  if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_bad_num_in
    $error("mux_select_pipe: NUM_IN out of range");
  end

  typedef `MUX_WORD_T(WIDTH, SEL_W) word_t;

  word_t            r_out;
  word_t            r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic [SEL_W-1:0] r_ptr;

  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_data;
  logic             w_err;
  word_t            w_word;
  logic             w_accept;
  logic             w_drain;

  assign w_idx    = scan ? r_ptr : sel;
  assign in_ready = enable & ~r_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_drain  = ~r_out_valid | out_ready;
  assign w_word   = {w_data, w_idx, w_err};

  mux_select_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_comb (
    .i_idx  (w_idx),
    .i_d    (d),
    .o_data (w_data),
    .o_err  (w_err)
  );

  // Skid entry is only ever filled while the output is stalled, so draining it always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_word;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_word;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept && scan) begin
      r_ptr <= (r_ptr == SEL_W'(NUM_IN - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign q         = r_out.data;
  assign q_sel     = r_out.sel;
  assign q_err     = r_out.err;
  assign out_valid = r_out_valid;

`ifdef MUX_SELECT_PARITY_EN
  assign q_par = (^r_out.data) & ~r_out.err;
`endif

endmodule

// File: tb/tb_mux_select_pipe.sv
// Directed self-checking bench for mux_select_pipe: an 8-input and a 6-input instance.
// Parity checks are compiled in when MUX_SELECT_PARITY_EN is defined.
module tb_mux_select_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // 8-input instance
  logic        a_enable, a_scan, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_q_err;
  logic [2:0]  a_sel, a_q_sel;
  logic [63:0] a_d;
  logic [7:0]  a_q;
  // 6-input instance
  logic        b_enable, b_scan, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_q_err;
  logic [2:0]  b_sel, b_q_sel;
  logic [47:0] b_d;
  logic [7:0]  b_q;
`ifdef MUX_SELECT_PARITY_EN
  logic        a_q_par, b_q_par;
`endif

  mux_select_pipe #(.WIDTH(8), .NUM_IN(8), .SEL_W(3)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (a_enable),
    .scan      (a_scan),
    .sel       (a_sel),
    .d         (a_d),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .q         (a_q),
    .q_sel     (a_q_sel),
    .q_err     (a_q_err),
`ifdef MUX_SELECT_PARITY_EN
    .q_par     (a_q_par),
`endif
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  mux_select_pipe #(.WIDTH(8), .NUM_IN(6), .SEL_W(3)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (b_enable),
    .scan      (b_scan),
    .sel       (b_sel),
    .d         (b_d),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .q         (b_q),
    .q_sel     (b_q_sel),
    .q_err     (b_q_err),
`ifdef MUX_SELECT_PARITY_EN
    .q_par     (b_q_par),
`endif
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({a_out_valid, a_q, a_q_sel, a_q_err} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b q=%h sel=%0d err=%b, want all 0",
               a_out_valid, a_q, a_q_sel, a_q_err);
    end
    n_checks++;
    if ({b_out_valid, b_q, b_q_sel, b_q_err} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b q=%h sel=%0d err=%b, want all 0",
               b_out_valid, b_q, b_q_sel, b_q_err);
    end
    tick();
    rst_n    = 1'b1;
    a_enable = 1'b1;
    b_enable = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
  endtask

  task automatic test_single;
    a_d[3*8 +: 8] = 8'hA5;
    a_sel         = 3'd3;
    a_scan        = 1'b0;
    a_out_ready   = 1'b1;
    a_in_valid    = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_q, a_q_sel, a_q_err} !== {1'b1, 8'hA5, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL single: got v=%b q=%h sel=%0d err=%b, want v=1 q=a5 sel=3 err=0",
               a_out_valid, a_q, a_q_sel, a_q_err);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: out_valid got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure;
    a_d[1*8 +: 8] = 8'h11;
    a_d[2*8 +: 8] = 8'h22;
    a_d[5*8 +: 8] = 8'h55;
    a_out_ready   = 1'b0;
    a_sel         = 3'd1;
    a_in_valid    = 1'b1;
    tick();
    a_sel = 3'd2;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready: got %b want 0", a_in_ready);
    end
    n_checks++;
    if ({a_out_valid, a_q} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL bp_first_held: got v=%b q=%h want v=1 q=11", a_out_valid, a_q);
    end
    a_sel = 3'd5;  // offered while in_ready=0; must never be captured
    tick();
    n_checks++;
    if ({a_out_valid, a_q, a_q_sel} !== {1'b1, 8'h11, 3'd1}) begin
      n_fail++;
      $display("FAIL bp_stable: got v=%b q=%h sel=%0d want v=1 q=11 sel=1",
               a_out_valid, a_q, a_q_sel);
    end
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_q, a_q_sel, a_in_ready} !== {1'b1, 8'h22, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b q=%h sel=%0d rdy=%b want v=1 q=22 sel=2 rdy=1",
               a_out_valid, a_q, a_q_sel, a_in_ready);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_scan_wrap;
    for (int i = 0; i < 8; i++) a_d[i*8 +: 8] = 8'(i);
    a_scan      = 1'b1;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if ({a_out_valid, a_q_sel, a_q} !== {1'b1, 3'(k % 8), 8'(k % 8)}) begin
        n_fail++;
        $display("FAIL scan_step%0d: got v=%b sel=%0d q=%h want v=1 sel=%0d q=%h",
                 k, a_out_valid, a_q_sel, a_q, k % 8, k % 8);
      end
    end
    a_in_valid = 1'b0;
    n_checks++;
    if (u_a.r_ptr !== 3'd1) begin
      n_fail++;
      $display("FAIL scan_ptr_end: got %0d want 1", u_a.r_ptr);
    end
  endtask

  task automatic test_enable;
    a_enable   = 1'b0;
    a_in_valid = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_in_ready: got %b want 0", a_in_ready);
    end
    tick();
    tick();
    n_checks++;
    if ({a_out_valid, u_a.r_ptr} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL en_frozen: got v=%b ptr=%0d want v=0 ptr=1", a_out_valid, u_a.r_ptr);
    end
    a_in_valid = 1'b0;
    a_enable   = 1'b1;
  endtask

  task automatic test_reset_mid;
    a_scan      = 1'b1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    tick();
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_in_ready, u_a.r_ptr, a_q} !== {1'b0, 3'd3, 8'h01}) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got rdy=%b ptr=%0d q=%h want rdy=0 ptr=3 q=01",
               a_in_ready, u_a.r_ptr, a_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_q, u_a.r_ptr} !== {1'b0, 8'h00, 3'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_async: got v=%b q=%h ptr=%0d want v=0 q=00 ptr=0",
               a_out_valid, a_q, u_a.r_ptr);
    end
    #1;
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    tick();
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_empty: got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready);
    end
    a_scan = 1'b0;
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < 6; i++) b_d[i*8 +: 8] = 8'h10 + 8'(i);
    b_scan      = 1'b0;
    b_sel       = 3'd7;
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n_checks++;
    if ({b_out_valid, b_q, b_q_sel, b_q_err} !== {1'b1, 8'h00, 3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL oor_sel7: got v=%b q=%h sel=%0d err=%b want v=1 q=00 sel=7 err=1",
               b_out_valid, b_q, b_q_sel, b_q_err);
    end
    b_scan     = 1'b1;
    b_in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_checks++;
      if ({b_q_sel, b_q, b_q_err} !== {3'(k % 6), 8'h10 + 8'(k % 6), 1'b0}) begin
        n_fail++;
        $display("FAIL oor_scan%0d: got sel=%0d q=%h err=%b want sel=%0d q=%h err=0",
                 k, b_q_sel, b_q, b_q_err, k % 6, 8'h10 + (k % 6));
      end
    end
    b_in_valid = 1'b0;
    b_scan     = 1'b0;
    tick();
  endtask

`ifdef MUX_SELECT_PARITY_EN
  task automatic test_parity;
    a_scan        = 1'b0;
    a_out_ready   = 1'b1;
    a_d[3*8 +: 8] = 8'hA5;
    a_d[4*8 +: 8] = 8'h07;
    a_sel         = 3'd3;
    a_in_valid    = 1'b1;
    tick();
    a_sel = 3'd4;
    n_checks++;
    if ({a_q, a_q_par} !== {8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL par_a5: got q=%h par=%b want q=a5 par=0", a_q, a_q_par);
    end
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_q, a_q_par} !== {8'h07, 1'b1}) begin
      n_fail++;
      $display("FAIL par_07: got q=%h par=%b want q=07 par=1", a_q, a_q_par);
    end
    b_sel      = 3'd6;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n_checks++;
    if ({b_q_err, b_q_par} !== 2'b10) begin
      n_fail++;
      $display("FAIL par_err: got err=%b par=%b want err=1 par=0", b_q_err, b_q_par);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    {a_enable, a_scan, a_in_valid, a_out_ready, a_sel, a_d} = '0;
    {b_enable, b_scan, b_in_valid, b_out_ready, b_sel, b_d} = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_scan_wrap();
    test_enable();
    test_reset_mid();
    test_out_of_range();
`ifdef MUX_SELECT_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
